mm_fetch_scheduler: RTL and testbench

Sequences operand fetches for the matrix multiplier. It turns the controller's `fetch_row`/`fetch_col` pulses into in-order read bursts on a single shared memory port and assembles the returned words into the `mem_buffer` operand vector. It drives `fetch_stall`/`data_stall` back to the control unit until each operand vector is complete. It sits between `control_unit` and external memory.

---
 rtl/mm_fetch_scheduler.sv | 167 ++++++++++++++++
 tb/tb_mm_fetch_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_fetch_scheduler.sv
// Operand fetch scheduler: turns row/column fetch pulses into in-order read bursts
// on one memory port and assembles the returned words into mem_buffer.
module mm_fetch_scheduler #(
   parameter int N          = 8,
   parameter int P          = 9,
   parameter int M          = 10,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int A_BASE     = 0,
   parameter int B_BASE     = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fetch_row,
   input  logic                    fetch_col,
   input  logic [$clog2(N)-1:0]    n,
   input  logic [$clog2(M)-1:0]    m,
   output logic                    mem_req,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic                    mem_gnt,
   input  logic                    mem_rd_valid,
   input  logic [DATA_WIDTH-1:0]   mem_rd_data,
   output logic [DATA_WIDTH-1:0]   mem_buffer [0:P-1],
   output logic                    buf_valid,
   output logic                    buf_is_col,
   output logic                    fetch_stall,
   output logic                    data_stall,
   output logic                    err
);
   // state   | meaning
   // S_IDLE  | no burst active, waiting for a pending entry
   // S_ISSUE | mem_req high, counting grants up to P
   // S_DRAIN | all requests granted, waiting for the remaining returns
   // S_DONE  | buf_valid pulse, release slot, chain to the other slot if pending
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int NW = $clog2(N);
   localparam int MW = $clog2(M);
   localparam int CW = $clog2(P + 1);

   logic [1:0]            state_q, state_d;
   logic                  row_vld_q, row_vld_d, col_vld_q, col_vld_d;
   logic                  col_older_q, col_older_d;
   logic [NW-1:0]         n_q, n_d;
   logic [MW-1:0]         m_q, m_d;
   logic                  cur_col_q, cur_col_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CW-1:0]         k_q, k_d, r_q, r_d, r_inc;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] buf_q [0:P-1];

   logic                  row_acc, col_acc, row_q_eff, col_q_eff;
   logic                  row_avail, col_avail, pick_col, rd_ok, rd_acc;
   logic [NW-1:0]         n_sel;
   logic [MW-1:0]         m_sel;
   logic [ADDR_WIDTH-1:0] start_addr, stride;

   always_comb begin
      row_acc   = fetch_row & ~row_vld_q;
      col_acc   = fetch_col & ~col_vld_q;
      // the slot being released in DONE no longer competes for service
      row_q_eff = row_vld_q & ~((state_q == S_DONE) & ~cur_col_q);
      col_q_eff = col_vld_q & ~((state_q == S_DONE) &  cur_col_q);
      row_avail = row_q_eff | row_acc;
      col_avail = col_q_eff | col_acc;
      n_sel     = row_vld_q ? n_q : n;
      m_sel     = col_vld_q ? m_q : m;
      if (row_avail && col_avail) begin
         if (row_q_eff && col_q_eff) pick_col = col_older_q;
         else                        pick_col = col_q_eff;
      end else begin
         pick_col = col_avail;
      end
      start_addr = pick_col ? ADDR_WIDTH'(B_BASE) + ADDR_WIDTH'(m_sel)
                            : ADDR_WIDTH'(A_BASE) + ADDR_WIDTH'(P) * ADDR_WIDTH'(n_sel);
      stride     = cur_col_q ? ADDR_WIDTH'(M) : ADDR_WIDTH'(1);
      rd_ok      = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && (r_q != CW'(P));
      rd_acc     = mem_rd_valid & rd_ok;
      r_inc      = r_q + CW'(rd_acc);
   end

   always_comb begin
      state_d   = state_q;
      row_vld_d = row_vld_q | row_acc;
      col_vld_d = col_vld_q | col_acc;
      n_d       = row_acc ? n : n_q;
      m_d       = col_acc ? m : m_q;
      cur_col_d = cur_col_q;
      addr_d    = addr_q;
      k_d       = k_q;
      r_d       = r_inc;
      err_d     = err_q | (fetch_row & row_vld_q) | (fetch_col & col_vld_q)
                        | (mem_rd_valid & ~rd_ok);
      if (row_acc && col_vld_q) col_older_d = 1'b1;
      else if (col_acc)         col_older_d = 1'b0;
      else                      col_older_d = col_older_q;

      case (state_q)
         S_ISSUE: begin
            if (mem_gnt) begin
               k_d    = k_q + CW'(1);
               addr_d = addr_q + stride;
               if (k_q == CW'(P - 1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_inc == CW'(P)) state_d = S_DONE;
         end
         S_DONE: begin
            if (cur_col_q) col_vld_d = 1'b0;
            else           row_vld_d = 1'b0;
            state_d = S_IDLE;
         end
         default: ;
      endcase

      if (((state_q == S_IDLE) || (state_q == S_DONE)) && (row_avail || col_avail)) begin
         state_d   = S_ISSUE;
         cur_col_d = pick_col;
         addr_d    = start_addr;
         k_d       = '0;
         r_d       = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         row_vld_q   <= 1'b0;
         col_vld_q   <= 1'b0;
         col_older_q <= 1'b0;
         n_q         <= '0;
         m_q         <= '0;
         cur_col_q   <= 1'b0;
         addr_q      <= '0;
         k_q         <= '0;
         r_q         <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < P; i++) buf_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         row_vld_q   <= row_vld_d;
         col_vld_q   <= col_vld_d;
         col_older_q <= col_older_d;
         n_q         <= n_d;
         m_q         <= m_d;
         cur_col_q   <= cur_col_d;
         addr_q      <= addr_d;
         k_q         <= k_d;
         r_q         <= r_d;
         err_q       <= err_d;
         if (rd_acc) buf_q[r_q] <= mem_rd_data;
      end
   end

   assign mem_req     = (state_q == S_ISSUE);
   assign mem_addr    = addr_q;
   assign mem_buffer  = buf_q;
   assign buf_valid   = (state_q == S_DONE);
   assign buf_is_col  = cur_col_q;
   assign fetch_stall = (row_vld_q & col_vld_q) | ((row_vld_q | col_vld_q) & (state_q != S_IDLE));
   assign data_stall  = row_vld_q | col_vld_q;
   assign err         = err_q;
endmodule

// File: tb/tb_mm_fetch_scheduler.sv
// Bench for mm_fetch_scheduler: directed vector table, multi-cycle corner sequences,
// and randomized grant/latency traffic checked against a burst-level reference model.
module tb_mm_fetch_scheduler;
   localparam int N = 8, P = 9, M = 10, DW = 16, AW = 16, A_BASE = 0, B_BASE = 256;

   logic          clk = 1'b0;
   logic          rst, fetch_row, fetch_col;
   logic [2:0]    n;
   logic [3:0]    m;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_gnt, mem_rd_valid;
   logic [DW-1:0] mem_rd_data;
   logic [DW-1:0] mem_buffer [0:P-1];
   logic          buf_valid, buf_is_col, fetch_stall, data_stall, err;

   always #5 clk = ~clk;

   mm_fetch_scheduler #(.N(N), .P(P), .M(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                        .A_BASE(A_BASE), .B_BASE(B_BASE)) dut (
      .clk(clk), .rst(rst), .fetch_row(fetch_row), .fetch_col(fetch_col), .n(n), .m(m),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rd_valid(mem_rd_valid),
      .mem_rd_data(mem_rd_data), .mem_buffer(mem_buffer), .buf_valid(buf_valid),
      .buf_is_col(buf_is_col), .fetch_stall(fetch_stall), .data_stall(data_stall), .err(err));

   typedef struct { bit col; int idx; } fetch_t;
   typedef struct { int due; logic [DW-1:0] data; } ret_t;
   typedef struct { bit col; int idx; int lat; int exp_first; int exp_done; } vec_t;

   int            n_cmp = 0, n_bad = 0, cyc = 0;
   int            bv_count = 0, bv_cyc = 0, n_fetch = 0, last_due = 0;
   fetch_t        exp_q[$];
   logic [AW-1:0] glog[$];
   ret_t          rq[$];
   bit            rand_gnt = 1'b0, pend_hold = 1'b0;
   int            lat_min = 1, lat_max = 1;
   logic [AW-1:0] hold_addr;
   logic [DW-1:0] salt = '0;

   function automatic logic [AW-1:0] exp_addr(bit col, int idx, int i);
      int a;
      a = col ? (B_BASE + idx + i * M) : (A_BASE + idx * P + i);
      return AW'(a);
   endfunction

   function automatic logic [DW-1:0] word(logic [AW-1:0] a);
      return DW'(a) ^ salt;
   endfunction

   task automatic check(string name, longint act, longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(string name, string what);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   task automatic push_fetch(bit col, int idx);
      fetch_t f;
      f.col = col;
      f.idx = idx;
      exp_q.push_back(f);
      n_fetch++;
   endtask

   task automatic monitor();
      fetch_t        f;
      logic [AW-1:0] a, ea;
      int            bad_a, bad_d;
      logic [AW-1:0] got_a, req_a;
      logic [DW-1:0] got_d, req_d;
      if (pend_hold) begin
         check("hold_req", mem_req, 1);
         check("hold_addr", mem_addr, hold_addr);
      end
      if (buf_valid === 1'b1) begin
         bv_count++;
         bv_cyc = cyc;
         if (exp_q.size() == 0) begin
            fail_now("unexpected_buf_valid", "buf_valid=1 with no fetch outstanding, required 0");
         end else begin
            f = exp_q.pop_front();
            check("buf_is_col", buf_is_col, f.col);
            check("data_stall_at_valid", data_stall, 1);
            check("burst_grants", glog.size(), P);
            if (glog.size() == P) begin
               bad_a = -1;
               bad_d = -1;
               got_a = '0; req_a = '0; got_d = '0; req_d = '0;
               for (int i = 0; i < P; i++) begin
                  a  = glog.pop_front();
                  ea = exp_addr(f.col, f.idx, i);
                  if (a != ea && bad_a < 0) begin bad_a = i; got_a = a; req_a = ea; end
                  if (mem_buffer[i] != word(ea) && bad_d < 0) begin
                     bad_d = i; got_d = mem_buffer[i]; req_d = word(ea);
                  end
               end
               n_cmp++;
               if (bad_a >= 0) begin
                  n_bad++;
                  $display("FAIL burst_addr[%0d]: got %0d, required %0d (cycle %0d)", bad_a, got_a, req_a, cyc);
               end
               n_cmp++;
               if (bad_d >= 0) begin
                  n_bad++;
                  $display("FAIL buffer[%0d]: got %0h, required %0h (cycle %0d)", bad_d, got_d, req_d, cyc);
               end
            end else begin
               glog.delete();
            end
         end
      end
   endtask

   // One clock cycle: drive memory-side inputs for the current cycle, clock, observe.
   task automatic step();
      bit   g;
      int   due;
      ret_t r;
      g = rand_gnt ? bit'($urandom_range(0, 1)) : 1'b1;
      mem_gnt = g;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         r = rq.pop_front();
         mem_rd_valid = 1'b1;
         mem_rd_data  = r.data;
      end else begin
         mem_rd_valid = 1'b0;
         mem_rd_data  = DW'($urandom);
      end
      if (!rst && mem_req === 1'b1 && g) begin
         due = cyc + $urandom_range(lat_min, lat_max);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         glog.push_back(mem_addr);
         r.due  = due;
         r.data = word(mem_addr);
         rq.push_back(r);
      end
      pend_hold = !rst && (mem_req === 1'b1) && !g;
      hold_addr = mem_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         n_fetch -= exp_q.size();
         exp_q.delete();
         glog.delete();
         rq.delete();
         last_due = cyc;
      end
      monitor();
   endtask

   task automatic wait_idle(string name, int budget);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || data_stall !== 1'b0) && c < budget) begin
         step();
         c++;
      end
      if (c >= budget) fail_now(name, "timeout waiting for burst completion");
   endtask

   task automatic check_reset_vals(string tag);
      int nz;
      nz = 0;
      for (int i = 0; i < P; i++) if (mem_buffer[i] !== '0) nz++;
      check({tag, "_mem_req"}, mem_req, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_buf_valid"}, buf_valid, 0);
      check({tag, "_buf_is_col"}, buf_is_col, 0);
      check({tag, "_fetch_stall"}, fetch_stall, 0);
      check({tag, "_data_stall"}, data_stall, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_buffer_nonzero"}, nz, 0);
   endtask

   initial begin
      vec_t vt [6];
      int   t, c, stall_low, bv0, kind, ni, mi;

      // directed vectors; gnt tied high, memory word = address
      vt[0] = '{1'b0, 2, 1,  18, 11};
      vt[1] = '{1'b1, 3, 1, 259, 11};
      vt[2] = '{1'b0, 7, 1,  63, 11};
      vt[3] = '{1'b1, 9, 1, 265, 11};
      vt[4] = '{1'b0, 0, 3,   0, 13};
      vt[5] = '{1'b1, 0, 2, 256, 12};

      rst = 1'b1; fetch_row = 1'b0; fetch_col = 1'b0; n = '0; m = '0;
      mem_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
      step();
      step();
      rst = 1'b0;
      check_reset_vals("reset");

      for (int i = 0; i < 6; i++) begin
         lat_min = vt[i].lat;
         lat_max = vt[i].lat;
         if (vt[i].col) begin fetch_col = 1'b1; m = 4'(vt[i].idx); end
         else           begin fetch_row = 1'b1; n = 3'(vt[i].idx); end
         push_fetch(vt[i].col, vt[i].idx);
         t = cyc;
         step();
         fetch_row = 1'b0;
         fetch_col = 1'b0;
         check("first_req", mem_req, 1);
         check("first_addr", mem_addr, vt[i].exp_first);
         check("data_stall_after_accept", data_stall, 1);
         wait_idle("vec_timeout", 200);
         check("done_cycle", bv_cyc - t, vt[i].exp_done);
      end

      // simultaneous row and column: row first, stall held throughout, no error
      lat_min = 1; lat_max = 1;
      fetch_row = 1'b1; n = 3'd0; fetch_col = 1'b1; m = 4'd0;
      push_fetch(1'b0, 0);
      push_fetch(1'b1, 0);
      step();
      fetch_row = 1'b0; fetch_col = 1'b0;
      stall_low = 0;
      c = 0;
      while (exp_q.size() != 0 && c < 300) begin
         if (fetch_stall !== 1'b1) stall_low++;
         step();
         c++;
      end
      if (c >= 300) fail_now("simul_timeout", "row+col bursts did not complete");
      check("simul_stall_low_cycles", stall_low, 0);
      check("simul_err", err, 0);
      wait_idle("simul_idle", 50);

      // second row pulse while a row is held: dropped, err sticky
      bv0 = bv_count;
      fetch_row = 1'b1; n = 3'd1;
      push_fetch(1'b0, 1);
      step();
      n = 3'd5;
      step();
      fetch_row = 1'b0;
      check("err_set", err, 1);
      wait_idle("drop_timeout", 200);
      repeat (20) step();
      check("err_sticky", err, 1);
      check("drop_single_bv", bv_count - bv0, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_vals("post_err");

      // reset at the 4th grant of a row burst, then a clean fetch
      fetch_row = 1'b1; n = 3'd4;
      push_fetch(1'b0, 4);
      step();
      fetch_row = 1'b0;
      c = 0;
      while (glog.size() < 3 && c < 50) begin step(); c++; end
      if (c >= 50) fail_now("midburst_timeout", "3 grants not seen");
      check("midburst_req_at_4th", mem_req, 1);
      bv0 = bv_count;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_vals("midburst");
      repeat (8) step();
      check("midburst_no_bv", bv_count - bv0, 0);
      fetch_row = 1'b1; n = 3'd6;
      push_fetch(1'b0, 6);
      step();
      fetch_row = 1'b0;
      wait_idle("post_rst_timeout", 200);
      check("post_rst_bv", bv_count - bv0, 1);

      // randomized grants and 1-4 cycle read latency
      rand_gnt = 1'b1; lat_min = 1; lat_max = 4;
      for (int it = 0; it < 40; it++) begin
         salt = DW'($urandom);
         kind = $urandom_range(0, 2);
         ni   = $urandom_range(0, N - 1);
         mi   = $urandom_range(0, M - 1);
         if (kind != 1) begin fetch_row = 1'b1; n = 3'(ni); push_fetch(1'b0, ni); end
         if (kind != 0) begin fetch_col = 1'b1; m = 4'(mi); push_fetch(1'b1, mi); end
         step();
         fetch_row = 1'b0; fetch_col = 1'b0;
         if (kind != 2 && $urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(0, 12)) step();
            if (kind == 0) begin fetch_col = 1'b1; m = 4'(mi); push_fetch(1'b1, mi); end
            else           begin fetch_row = 1'b1; n = 3'(ni); push_fetch(1'b0, ni); end
            step();
            fetch_row = 1'b0; fetch_col = 1'b0;
         end
         wait_idle("rand_timeout", 600);
      end
      check("rand_err", err, 0);
      check("bv_total", bv_count, n_fetch);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
